// File: rtl/async_fifo_pkg.sv
// Shared defaults for the single-clock FIFO and its storage.
package async_fifo_pkg;
   localparam int DEPTH_DEF     = 512;
   localparam int WIDTH_DEF     = 1024;
   localparam int PTR_WIDTH_DEF = 9;
endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x WIDTH array, one synchronous write port and one
// synchronous read port. Deliberately unreset so it maps onto block RAM.
module fifo_mem #(
   parameter int DEPTH     = 512,
   parameter int WIDTH     = 1024,
   parameter int PTR_WIDTH = 9
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [PTR_WIDTH-1:0] waddr,
   input  logic [WIDTH-1:0]     wdata,
   input  logic                 re,
   input  logic [PTR_WIDTH-1:0] raddr,
   output logic [WIDTH-1:0]     rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port: store the word when enabled.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read port: registered output, updated only on an enabled read so the
   // last word is held between reads.
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO: wrap-flag pointers, combinational full/empty,
// registered error flags, 1-cycle read latency.
module async_fifo
   import async_fifo_pkg::*;
#(
   parameter int DEPTH     = DEPTH_DEF,
   parameter int WIDTH     = WIDTH_DEF,
   parameter int PTR_WIDTH = PTR_WIDTH_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             full_o,
   input  logic             wr_en_i,
   output logic             wr_error_o,
   output logic [WIDTH-1:0] rdata_o,
   output logic             empty_o,
   input  logic             rd_en_i,
   output logic             rd_error_o
);

   localparam logic [PTR_WIDTH:0] PTR_ONE = 1;

   logic [PTR_WIDTH:0] wr_ptr, rd_ptr;
   logic               wr_ok, rd_ok;
   logic               rd_valid;
   logic [WIDTH-1:0]   mem_q;

   // Flags come straight from the pointers; the MSB distinguishes full from
   // empty when the addresses coincide.
   assign empty_o = (wr_ptr == rd_ptr);
   assign full_o  = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
                    (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);

   // Requests are judged on the pre-edge flags, so an empty FIFO never
   // forwards a same-cycle write to the read side.
   assign wr_ok = wr_en_i & ~full_o;
   assign rd_ok = rd_en_i & ~empty_o;

   // Pointer advance and registered error flags.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         wr_error_o <= 1'b0;
         rd_error_o <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
         wr_error_o <= wr_en_i & full_o;
         rd_error_o <= rd_en_i & empty_o;
      end
   end

   // The storage read register has no reset; this flag masks it to zero
   // until the first successful read after reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)      rd_valid <= 1'b0;
      else if (rd_ok) rd_valid <= 1'b1;
   end

   assign rdata_o = rd_valid ? mem_q : '0;

   fifo_mem #(
      .DEPTH     (DEPTH),
      .WIDTH     (WIDTH),
      .PTR_WIDTH (PTR_WIDTH)
   ) u_mem (
      .clk   (clk_i),
      .we    (wr_ok),
      .waddr (wr_ptr[PTR_WIDTH-1:0]),
      .wdata (wdata_i),
      .re    (rd_ok),
      .raddr (rd_ptr[PTR_WIDTH-1:0]),
      .rdata (mem_q)
   );

endmodule

// File: tb/tb_async_fifo.sv
// Randomized bench for async_fifo against a queue-based reference model.
module tb_async_fifo;
   import async_fifo_pkg::*;

   localparam int D = DEPTH_DEF;
   localparam int W = WIDTH_DEF;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic [W-1:0] wdata_i = '0;
   logic         full_o;
   logic         wr_en_i = 1'b0;
   logic         wr_error_o;
   logic [W-1:0] rdata_o;
   logic         empty_o;
   logic         rd_en_i = 1'b0;
   logic         rd_error_o;

   async_fifo #(.DEPTH(D), .WIDTH(W), .PTR_WIDTH(PTR_WIDTH_DEF)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wdata_i    (wdata_i),
      .full_o     (full_o),
      .wr_en_i    (wr_en_i),
      .wr_error_o (wr_error_o),
      .rdata_o    (rdata_o),
      .empty_o    (empty_o),
      .rd_en_i    (rd_en_i),
      .rd_error_o (rd_error_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference model: contents as a queue, plus expected output registers.
   logic [W-1:0] q[$];
   logic [W-1:0] m_rdata = '0;
   logic         m_werr  = 1'b0;
   logic         m_rerr  = 1'b0;

   int checks = 0;
   int errs   = 0;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h (low 128 bits) t=%0t", tag, got[127:0], exp[127:0], $time);
      end
   endtask

   function automatic logic [W-1:0] rword();
      logic [W-1:0] v;
      for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic chk_all(input string tag);
      chk({tag, ".full"},  W'(full_o),     W'(q.size() == D));
      chk({tag, ".empty"}, W'(empty_o),    W'(q.size() == 0));
      chk({tag, ".werr"},  W'(wr_error_o), W'(m_werr));
      chk({tag, ".rerr"},  W'(rd_error_o), W'(m_rerr));
      chk({tag, ".rdata"}, rdata_o,        m_rdata);
   endtask

   // One clock: drive at negedge, advance the model at posedge, check after.
   task automatic cycle(input string tag, input bit w, input bit r, output bit rok);
      logic [W-1:0] d;
      int           n;
      d = rword();
      @(negedge clk_i);
      wr_en_i = w;
      rd_en_i = r;
      wdata_i = d;
      @(posedge clk_i);
      n      = q.size();
      m_werr = w && (n == D);
      m_rerr = r && (n == 0);
      rok    = r && (n != 0);
      if (rok) m_rdata = q.pop_front();
      if (w && n != D) q.push_back(d);
      #1;
      chk_all(tag);
   endtask

   task automatic model_reset();
      q.delete();
      m_rdata = '0;
      m_werr  = 1'b0;
      m_rerr  = 1'b0;
   endtask

   initial begin
      bit           rok;
      logic [W-1:0] last;
      int           nw, nr, wg, rg, cyc;

      // Reset state.
      repeat (3) @(posedge clk_i);
      #1;
      chk_all("reset");
      @(negedge clk_i);
      rst_i = 1'b0;

      // Fill to full with no write errors.
      for (int i = 0; i < D; i++) cycle("fill", 1'b1, 1'b0, rok);
      chk("fill.full_end", W'(full_o), W'(1));

      // Drain in order.
      for (int i = 0; i < D; i++) cycle("drain", 1'b0, 1'b1, rok);
      chk("drain.empty_end", W'(empty_o), W'(1));

      // Overflow by one: 513th write is dropped.
      for (int i = 0; i < D + 1; i++) cycle("ovf_w", 1'b1, 1'b0, rok);
      chk("ovf.werr", W'(wr_error_o), W'(1));
      for (int i = 0; i < D; i++) cycle("ovf_r", 1'b0, 1'b1, rok);
      chk("ovf.empty_end", W'(empty_o), W'(1));

      // Underflow by one: rdata holds the 512th word.
      for (int i = 0; i < D; i++) cycle("unf_w", 1'b1, 1'b0, rok);
      last = q[D-1];
      for (int i = 0; i < D + 1; i++) cycle("unf_r", 1'b0, 1'b1, rok);
      chk("unf.rerr", W'(rd_error_o), W'(1));
      chk("unf.hold", rdata_o, last);
      cycle("unf_idle", 1'b0, 1'b0, rok);

      // Simultaneous write+read on empty (write wins, no bypass) and full.
      cycle("sim_empty", 1'b1, 1'b1, rok);
      for (int i = 0; i < D - 1; i++) cycle("sim_fill", 1'b1, 1'b0, rok);
      cycle("sim_full", 1'b1, 1'b1, rok);
      for (int i = 0; i < D; i++) cycle("sim_drain", 1'b0, 1'b1, rok);

      // Concurrent traffic with random 1..10 cycle gaps.
      nw = 0; nr = 0; cyc = 0;
      wg = $urandom_range(1, 10);
      rg = $urandom_range(1, 10);
      while ((nw < 500 || nr < 500) && cyc < 20000) begin
         bit w, r;
         w = (wg == 0) && (nw < 500);
         r = (rg == 0) && (nr < 500);
         cycle("conc", w, r, rok);
         if (w) begin nw++; wg = $urandom_range(1, 10); end
         else if (wg > 0) wg--;
         if (r) begin if (rok) nr++; rg = $urandom_range(1, 10); end
         else if (rg > 0) rg--;
         cyc++;
      end
      chk("conc.reads", W'(nr), W'(500));

      // Mid-cycle reset with entries held.
      for (int i = 0; i < 5; i++) cycle("mr_w", 1'b1, 1'b0, rok);
      @(negedge clk_i);
      wr_en_i = 1'b0;
      rd_en_i = 1'b0;
      #2 rst_i = 1'b1;
      #1;
      model_reset();
      chk("mr.empty", W'(empty_o), W'(1));
      chk("mr.rdata", rdata_o, '0);
      chk("mr.full",  W'(full_o), W'(0));
      @(negedge clk_i);
      rst_i = 1'b0;
      cycle("mr_rd", 1'b0, 1'b1, rok);
      chk("mr.rerr", W'(rd_error_o), W'(1));

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
